// File: rtl/fetch_sequencer_pkg.sv
// Shared types and helpers for the instruction fetch path.
// Decode imports is_two_byte so both sides agree on instruction length.
package fetch_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 8;
  localparam int LEN_BIT        = 7;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_OP,
    FETCH_OPND,
    ISSUE,
    DRAIN
  } fetch_state_e;

  // The top bit of the opcode marks an instruction that carries an operand byte.
  function automatic logic is_two_byte(input logic [DEFAULT_DATA_W-1:0] opcode);
    return opcode[LEN_BIT];
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory read port and decode handshake between the fetch sequencer and its neighbours.
interface fetch_sequencer_if #(
  parameter int ADDR_W = fetch_pkg::DEFAULT_ADDR_W,
  parameter int DATA_W = fetch_pkg::DEFAULT_DATA_W
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_opcode;
  logic [DATA_W-1:0] instr_operand;

  modport master (
    output mem_req, mem_addr, instr_valid, instr_opcode, instr_operand,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr_opcode, instr_operand,
    output mem_ack, mem_rdata, instr_ready
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Fetches 1- or 2-byte instructions over the shared memory port, steers the PC,
// and hands each instruction to decode. Redirects never abandon an outstanding read.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] current_address,
  output logic [ADDR_W-1:0] next_address,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  fetch_sequencer_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
  logic [ADDR_W-1:0] addr_inc;

  assign addr_inc = current_address + ADDR_W'(1);

  // Next-state and PC steering; a branch overrides everything except IDLE.
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    operand_d    = operand_q;
    drain_addr_d = drain_addr_q;
    next_address = current_address;
    if (!reset) begin
      next_address = '0;
    end else begin
      case (state_q)
        IDLE: state_d = FETCH_OP;
        FETCH_OP, FETCH_OPND: begin
          if (branch_valid) begin
            next_address = branch_target;
            if (bus.mem_ack) begin
              state_d = FETCH_OP;
            end else begin
              drain_addr_d = current_address;
              state_d      = DRAIN;
            end
          end else if (bus.mem_ack) begin
            next_address = addr_inc;
            if (state_q == FETCH_OP) begin
              opcode_d = bus.mem_rdata;
              if (is_two_byte(bus.mem_rdata)) begin
                state_d = FETCH_OPND;
              end else begin
                operand_d = '0;
                state_d   = ISSUE;
              end
            end else begin
              operand_d = bus.mem_rdata;
              state_d   = ISSUE;
            end
          end
        end
        ISSUE: begin
          if (branch_valid) begin
            next_address = branch_target;
            state_d      = FETCH_OP;
          end else if (bus.instr_ready) begin
            state_d = FETCH_OP;
          end
        end
        DRAIN: begin
          if (branch_valid) next_address = branch_target;
          if (bus.mem_ack) state_d = FETCH_OP;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      opcode_q     <= '0;
      operand_q    <= '0;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      operand_q    <= operand_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // While draining, the read address must stay on the abandoned fetch, not the new PC.
  assign bus.mem_req       = (state_q == FETCH_OP) || (state_q == FETCH_OPND) || (state_q == DRAIN);
  assign bus.mem_addr      = (state_q == DRAIN) ? drain_addr_q : current_address;
  assign bus.instr_valid   = (state_q == ISSUE);
  assign bus.instr_opcode  = opcode_q;
  assign bus.instr_operand = operand_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a PC register, wait-state memory model
// and a scoreboard that checks every instruction accepted by decode.
module tb_fetch_sequencer;

  logic       clock;
  logic       reset;
  logic [7:0] pc;
  logic [7:0] next_address;
  logic       branch_valid;
  logic [7:0] branch_target;
  logic [7:0] mem [256];
  int         wait_states;
  int         wait_cnt;
  int         check_count;
  int         pass_count;
  logic [15:0] exp_q [$];

  fetch_sequencer_if bus_if ();

  fetch_sequencer dut (
    .clock           (clock),
    .reset           (reset),
    .current_address (pc),
    .next_address    (next_address),
    .branch_valid    (branch_valid),
    .branch_target   (branch_target),
    .bus             (bus_if)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // PC register has no reset of its own; it converges while next_address is forced to 0.
  always @(posedge clock) pc <= next_address;

  // Memory acknowledges after wait_states cycles of a held request.
  assign bus_if.mem_ack   = bus_if.mem_req && (wait_cnt >= wait_states);
  assign bus_if.mem_rdata = mem[bus_if.mem_addr];

  always @(posedge clock or negedge reset) begin
    if (!reset) wait_cnt <= 0;
    else if (bus_if.mem_req && !bus_if.mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic apply_stimulus(input logic ready, input logic br, input logic [7:0] target);
    bus_if.instr_ready = ready;
    branch_valid       = br;
    branch_target      = target;
  endtask

  // Scoreboard monitor plus a hold check on stalled instructions.
  logic        prev_stall;
  logic [15:0] prev_instr;
  always @(negedge clock) begin
    if (reset && prev_stall) begin
      check_output("valid_held", {15'd0, bus_if.instr_valid}, 16'd1);
      check_output("instr_held", {bus_if.instr_opcode, bus_if.instr_operand}, prev_instr);
    end
    if (reset && bus_if.instr_valid && bus_if.instr_ready) begin
      if (exp_q.size() == 0) begin
        check_count++;
        $display("[TB] FAIL unexpected_instr: got %h, expected none",
                 {bus_if.instr_opcode, bus_if.instr_operand});
      end else begin
        check_output("instr", {bus_if.instr_opcode, bus_if.instr_operand}, exp_q.pop_front());
      end
    end
    prev_stall = reset && bus_if.instr_valid && !bus_if.instr_ready && !branch_valid;
    prev_instr = {bus_if.instr_opcode, bus_if.instr_operand};
  end

  initial begin
    check_count = 0;
    pass_count  = 0;
    prev_stall  = 1'b0;
    prev_instr  = '0;
    wait_states = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h05; mem[8'h01] = 8'h06; mem[8'h02] = 8'h07; mem[8'h03] = 8'h08;
    mem[8'h10] = 8'h8A; mem[8'h11] = 8'h33; mem[8'h12] = 8'h01;
    mem[8'h20] = 8'h09; mem[8'h21] = 8'h0A; mem[8'h40] = 8'h77; mem[8'hFF] = 8'h8C;
    apply_stimulus(1'b1, 1'b0, 8'h00);
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) next_cycle();
    sample();
    check_output("rst_mem_req", {15'd0, bus_if.mem_req}, 16'd0);
    check_output("rst_valid", {15'd0, bus_if.instr_valid}, 16'd0);
    check_output("rst_opcode", {8'd0, bus_if.instr_opcode}, 16'd0);
    check_output("rst_operand", {8'd0, bus_if.instr_operand}, 16'd0);
    check_output("rst_next", {8'd0, next_address}, 16'd0);
    check_output("rst_pc", {8'd0, pc}, 16'd0);

    // Zero-wait 1-byte instructions, then a 3-cycle decode stall on 0x07.
    exp_q.push_back(16'h0500); exp_q.push_back(16'h0600); exp_q.push_back(16'h0700);
    next_cycle(); reset = 1'b1;
    sample();
    check_output("idle_mem_req", {15'd0, bus_if.mem_req}, 16'd0);
    next_cycle(); sample();
    check_output("f0_mem_req", {15'd0, bus_if.mem_req}, 16'd1);
    check_output("f0_mem_addr", {8'd0, bus_if.mem_addr}, 16'h00);
    check_output("f0_next", {8'd0, next_address}, 16'h01);
    next_cycle(); sample();
    check_output("i0_valid", {15'd0, bus_if.instr_valid}, 16'd1);
    check_output("i0_pc", {8'd0, pc}, 16'h01);
    check_output("i0_mem_req", {15'd0, bus_if.mem_req}, 16'd0);
    next_cycle(); sample();
    check_output("f1_mem_addr", {8'd0, bus_if.mem_addr}, 16'h01);
    check_output("f1_next", {8'd0, next_address}, 16'h02);
    next_cycle(); sample();
    check_output("i1_pc", {8'd0, pc}, 16'h02);
    next_cycle(); apply_stimulus(1'b0, 1'b0, 8'h00); sample();
    check_output("f2_mem_addr", {8'd0, bus_if.mem_addr}, 16'h02);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      if (i == 0) next_cycle();
      sample();
      check_output("stall_valid", {15'd0, bus_if.instr_valid}, 16'd1);
      check_output("stall_mem_req", {15'd0, bus_if.mem_req}, 16'd0);
      check_output("stall_pc", {8'd0, pc}, 16'h03);
    end
    next_cycle(); apply_stimulus(1'b1, 1'b0, 8'h00); sample();
    next_cycle(); apply_stimulus(1'b0, 1'b0, 8'h00); sample();
    check_output("resume_mem_req", {15'd0, bus_if.mem_req}, 16'd1);
    check_output("resume_mem_addr", {8'd0, bus_if.mem_addr}, 16'h03);

    // Branch out of ISSUE to a 2-byte instruction at 0x10.
    next_cycle(); apply_stimulus(1'b0, 1'b1, 8'h10); sample();
    check_output("br_issue_next", {8'd0, next_address}, 16'h10);
    next_cycle(); apply_stimulus(1'b1, 1'b0, 8'h00); exp_q.push_back(16'h8A33); sample();
    check_output("br_valid_drop", {15'd0, bus_if.instr_valid}, 16'd0);
    check_output("two_op_addr", {8'd0, bus_if.mem_addr}, 16'h10);
    next_cycle(); sample();
    check_output("two_opnd_addr", {8'd0, bus_if.mem_addr}, 16'h11);
    check_output("two_opnd_valid", {15'd0, bus_if.instr_valid}, 16'd0);
    next_cycle(); sample();
    check_output("two_pc", {8'd0, pc}, 16'h12);
    check_output("two_valid", {15'd0, bus_if.instr_valid}, 16'd1);

    // Branch during the first wait cycle of a 2-wait read: drain old address, refetch at 0x20.
    next_cycle(); apply_stimulus(1'b0, 1'b0, 8'h00); sample();
    next_cycle(); apply_stimulus(1'b0, 1'b1, 8'h40); wait_states = 2; sample();
    next_cycle(); apply_stimulus(1'b0, 1'b1, 8'h20); sample();
    check_output("wait_mem_addr", {8'd0, bus_if.mem_addr}, 16'h40);
    check_output("wait_mem_ack", {15'd0, bus_if.mem_ack}, 16'd0);
    check_output("wait_br_next", {8'd0, next_address}, 16'h20);
    next_cycle(); apply_stimulus(1'b0, 1'b0, 8'h00); sample();
    check_output("drain_mem_req", {15'd0, bus_if.mem_req}, 16'd1);
    check_output("drain_mem_addr", {8'd0, bus_if.mem_addr}, 16'h40);
    check_output("drain_pc", {8'd0, pc}, 16'h20);
    check_output("drain_valid", {15'd0, bus_if.instr_valid}, 16'd0);
    next_cycle(); sample();
    check_output("drain_ack", {15'd0, bus_if.mem_ack}, 16'd1);
    check_output("drain_ack_addr", {8'd0, bus_if.mem_addr}, 16'h40);
    check_output("drain_ack_valid", {15'd0, bus_if.instr_valid}, 16'd0);
    next_cycle(); exp_q.push_back(16'h0900); sample();
    check_output("refetch_addr", {8'd0, bus_if.mem_addr}, 16'h20);
    check_output("refetch_valid", {15'd0, bus_if.instr_valid}, 16'd0);
    next_cycle(); next_cycle(); sample();
    check_output("refetch_ack", {15'd0, bus_if.mem_ack}, 16'd1);
    next_cycle(); apply_stimulus(1'b1, 1'b0, 8'h00); wait_states = 0; sample();

    // 2-byte instruction at 0xFF wraps its operand fetch to 0x00.
    next_cycle(); apply_stimulus(1'b0, 1'b0, 8'h00); sample();
    next_cycle(); apply_stimulus(1'b0, 1'b1, 8'hFF); sample();
    next_cycle(); apply_stimulus(1'b0, 1'b0, 8'h00); exp_q.push_back(16'h8C05); sample();
    check_output("wrap_op_addr", {8'd0, bus_if.mem_addr}, 16'hFF);
    check_output("wrap_next", {8'd0, next_address}, 16'h00);
    next_cycle(); apply_stimulus(1'b1, 1'b0, 8'h00); sample();
    check_output("wrap_opnd_addr", {8'd0, bus_if.mem_addr}, 16'h00);
    next_cycle(); sample();
    check_output("wrap_pc", {8'd0, pc}, 16'h01);

    // Reset in the middle of an operand fetch.
    next_cycle(); apply_stimulus(1'b0, 1'b0, 8'h00); sample();
    next_cycle(); apply_stimulus(1'b0, 1'b1, 8'h10); sample();
    next_cycle(); apply_stimulus(1'b0, 1'b0, 8'h00); sample();
    next_cycle(); sample();
    check_output("pre_rst_mem_addr", {8'd0, bus_if.mem_addr}, 16'h11);
    #2 reset = 1'b0;
    #1;
    check_output("mid_rst_mem_req", {15'd0, bus_if.mem_req}, 16'd0);
    check_output("mid_rst_valid", {15'd0, bus_if.instr_valid}, 16'd0);
    check_output("mid_rst_next", {8'd0, next_address}, 16'h00);
    repeat (2) next_cycle();
    sample();
    check_output("mid_rst_pc", {8'd0, pc}, 16'h00);
    exp_q.push_back(16'h0500);
    next_cycle(); reset = 1'b1; apply_stimulus(1'b1, 1'b0, 8'h00); sample();
    next_cycle(); sample();
    check_output("post_rst_req", {15'd0, bus_if.mem_req}, 16'd1);
    check_output("post_rst_addr", {8'd0, bus_if.mem_addr}, 16'h00);
    next_cycle(); sample();
    check_output("post_rst_pc", {8'd0, pc}, 16'h01);
    next_cycle(); apply_stimulus(1'b0, 1'b0, 8'h00); sample();
    next_cycle(); sample();
    check_output("post_rst_opcode", {8'd0, bus_if.instr_opcode}, 16'h06);

    check_output("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the program counter's `next_address` input and consumes its `current_address` output. Fetches each instruction byte over the shared (Von Neumann) memory port.
- Assembles 1- or 2-byte instructions and hands them to decode with a valid/ready handshake.
- Branch redirects take priority. A memory transaction that is still outstanding is completed and its data discarded, never abandoned.

Parameters:
- ADDR_W, 8, address width; matches the PC.
- DATA_W, 8, memory data and instruction byte width.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; asserted when 0.
- current_address  in  ADDR_W  PC register output.
- next_address  out  ADDR_W  PC register input (combinational).
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  memory read address.
- mem_ack  in  1  read completes this cycle; mem_rdata valid.
- mem_rdata  in  DATA_W  read data.
- instr_valid  out  1  instr_opcode and instr_operand valid.
- instr_ready  in  1  decode accepts the instruction.
- instr_opcode  out  DATA_W  first instruction byte.
- instr_operand  out  DATA_W  second byte; 0 for 1-byte instructions.
- branch_valid  in  1  redirect request, 1-cycle pulse.
- branch_target  in  ADDR_W  redirect address.

Behaviour:
- States: IDLE, FETCH_OP, FETCH_OPND, ISSUE, DRAIN.
- Reset asserted:
  - State is IDLE; instr_valid=0, opcode and operand registers are 0, mem_req=0.
  - next_address=0, so the PC converges to 0x00 regardless of its own reset.
- IDLE: next_address=current_address; moves to FETCH_OP on the first clock after reset releases.
- mem_req=1 in FETCH_OP, FETCH_OPND and DRAIN, otherwise 0.
- mem_addr=current_address, except in DRAIN, where it is drain_addr_q.
- Memory handshake:
  - Request and address are held stable until mem_ack.
  - mem_ack may arrive in the same cycle as the first assertion of mem_req (zero-wait).
- Default next_address is current_address (PC holds).
- FETCH_OP with mem_ack:
  - Capture opcode; next_address = current_address+1.
  - If opcode[7]=1 (2-byte instruction), go to FETCH_OPND.
  - Otherwise set operand=0 and go to ISSUE.
- FETCH_OPND with mem_ack: capture operand; next_address = current_address+1; go to ISSUE.
- ISSUE:
  - instr_valid=1; outputs stay stable until instr_ready.
  - On valid&ready, instr_valid drops the next cycle and the state becomes FETCH_OP.
  - There is no prefetch.
- Address arithmetic wraps modulo 2^ADDR_W: 0xFF+1 = 0x00. A 2-byte instruction at 0xFF reads its operand from 0x00.
- Latency: a 1-byte instruction with zero-wait memory is valid 1 cycle after its FETCH_OP cycle; a 2-byte instruction is valid after 2.
- branch_valid has highest priority. In that cycle next_address = branch_target, and:
  - IDLE: ignored; the PC is held at 0x00 and the state moves to FETCH_OP as normal.
  - ISSUE: instr_valid=0 next cycle; go to FETCH_OP. If instr_ready is also high, the instruction counts as consumed.
  - FETCH_OP/FETCH_OPND with mem_ack: discard the byte; go to FETCH_OP.
  - FETCH_OP/FETCH_OPND without mem_ack: drain_addr_q <= current_address; go to DRAIN.
  - DRAIN: target updated; stay in DRAIN. If mem_ack is also high, go to FETCH_OP.
- DRAIN: next_address holds; on mem_ack the data is discarded and the state becomes FETCH_OP.
- Reset mid-operation: asynchronous return to IDLE. mem_req drops immediately and the outstanding transaction is abandoned; the memory is reset by the same signal.
- mem_ack outside mem_req=1 is ignored.

Decomposition:
- Package fetch_pkg holds:
  - state enum (IDLE, FETCH_OP, FETCH_OPND, ISSUE, DRAIN);
  - ADDR_W and DATA_W defaults;
  - LEN_BIT=7 and an is_two_byte(opcode) function, which decode shares.
- Single module; no sub-module is warranted.
- Next-address mux is an always-combinational block; state, opcode, operand and drain_addr_q are flops.

Test Plan:
- Zero-wait memory, 1-byte opcodes 0x05/0x06 at 0x00/0x01, instr_ready=1 -> opcode 0x05 valid with operand 0x00; next fetch at 0x01; PC steps 0x00 -> 0x01 -> 0x02.
- 2-byte opcode 0x8A at 0x10 with operand 0x33 -> a single instr_valid with opcode 0x8A, operand 0x33; PC ends at 0x12.
- instr_ready held low 3 cycles -> instr_valid and outputs stable; mem_req=0; PC constant; fetch resumes the cycle after the handshake.
- 2-cycle-wait memory; branch_valid to 0x20 in the first wait cycle ->
  - mem_addr stays at the old address until mem_ack, and that byte is discarded;
  - the next request is at 0x20;
  - no spurious instr_valid.
- 2-byte opcode at 0xFF -> operand read from 0x00; PC wraps to 0x01.
- reset driven to 0 during FETCH_OPND -> mem_req and instr_valid go to 0 immediately; next_address=0x00; after release, the first request is at 0x00.
